// File: rtl/trap_sequencer.sv
// trap_sequencer
// Drives the machine-mode CSR file through a trap entry (save mepc/mcause,
// push MIE into MPIE, fetch mtvec) or an MRET (fetch mepc, pop MPIE into MIE).
// When the sequence finishes, it emits a one-cycle fetch redirect.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   trap_req            trap request, with trap_pc / trap_cause (bit 31 = interrupt)
//   mret_req            MRET request
//   csr_addr/wdata/write  CSR write port (initiator side)
//   csr_set/_valid, csr_clear/_valid  unused set/clear ports, tied to 0
//   csr_rdata           combinational read data for csr_addr
//   req_ack             one-cycle pulse in the cycle a request is accepted
//   busy                high whenever the sequencer is not idle
//   redirect_valid/pc   one-cycle fetch redirect; pc is 0 when not valid
//
// Handshake: a request is accepted when it is high while the sequencer is
// idle and out of reset. The requester must hold the request until it sees
// req_ack. A trap outranks an MRET in the same cycle, and the losing MRET is
// dropped.
module trap_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_write,
    output logic [31:0] csr_set,
    output logic        csr_set_valid,
    output logic [31:0] csr_clear,
    output logic        csr_clear_valid,
    input  logic [31:0] csr_rdata,
    output logic        req_ack,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        UPD_STATUS,
        RD_TVEC,
        R_EPC,
        R_STATUS,
        REDIRECT
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic [31:0] rdata_aligned;

    assign rdata_aligned   = {csr_rdata[31:2], 2'b00};
    assign csr_set         = 32'h0;
    assign csr_set_valid   = 1'b0;
    assign csr_clear       = 32'h0;
    assign csr_clear_valid = 1'b0;
    assign busy            = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= 32'h0;
            cause_q  <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        target_d       = target_q;
        csr_addr       = 12'h0;
        csr_wdata      = 32'h0;
        csr_write      = 1'b0;
        req_ack        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (state_q)
            IDLE: begin
                // The state register is already IDLE while in reset, so the
                // rst term is what keeps req_ack low during reset.
                if (rst && (trap_req || mret_req)) begin
                    req_ack = 1'b1;
                    pc_d    = trap_pc;
                    cause_d = trap_cause;
                    state_d = trap_req ? W_EPC : R_EPC;
                end
            end
            W_EPC: begin
                csr_addr  = CSR_MEPC;
                csr_wdata = {pc_q[31:2], 2'b00};
                csr_write = 1'b1;
                state_d   = W_CAUSE;
            end
            W_CAUSE: begin
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
                csr_write = 1'b1;
                state_d   = UPD_STATUS;
            end
            UPD_STATUS: begin
                // Read-modify-write in a single cycle: MPIE <= MIE, MIE <= 0.
                csr_addr     = CSR_MSTATUS;
                csr_wdata    = csr_rdata;
                csr_wdata[7] = csr_rdata[3];
                csr_wdata[3] = 1'b0;
                csr_write    = 1'b1;
                state_d      = RD_TVEC;
            end
            RD_TVEC: begin
                csr_addr = CSR_MTVEC;
                // Vectored mode only applies to interrupts. The cause*4
                // offset wraps modulo 2^32, so cause bit 30 drops out.
                if (csr_rdata[1:0] == 2'b01 && cause_q[31])
                    target_d = rdata_aligned + {cause_q[29:0], 2'b00};
                else
                    target_d = rdata_aligned;
                state_d = REDIRECT;
            end
            R_EPC: begin
                csr_addr = CSR_MEPC;
                target_d = rdata_aligned;
                state_d  = R_STATUS;
            end
            R_STATUS: begin
                // MIE <= MPIE, MPIE <= 1.
                csr_addr     = CSR_MSTATUS;
                csr_wdata    = csr_rdata;
                csr_wdata[3] = csr_rdata[7];
                csr_wdata[7] = 1'b1;
                csr_write    = 1'b1;
                state_d      = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
